// File: rtl/rvfpm_issue_ctrl_if.sv
// Issue, FPU-forward, writeback and fence signals of rvfpm_issue_ctrl.
// The controller uses the slave modport; the core/FPU environment uses master.
interface rvfpm_issue_ctrl_if #(
  parameter int X_ID_WIDTH   = 4,
  parameter int MAX_INFLIGHT = 4
);
  logic                              issue_valid;
  logic [31:0]                       issue_instr;
  logic [X_ID_WIDTH-1:0]             issue_id;
  logic                              issue_ready;
  logic                              issue_illegal;
  logic                              fpu_enable;
  logic [31:0]                       fpu_instr;
  logic [X_ID_WIDTH-1:0]             fpu_id;
  logic                              fpu_full;
  logic                              wb_valid;
  logic [X_ID_WIDTH-1:0]             wb_id;
  logic                              fence_req;
  logic                              fence_done;
  logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight_cnt;

  modport slave (
    input  issue_valid, issue_instr, issue_id, fpu_full, wb_valid, wb_id, fence_req,
    output issue_ready, issue_illegal, fpu_enable, fpu_instr, fpu_id, fence_done,
           inflight_cnt
  );

  modport master (
    output issue_valid, issue_instr, issue_id, fpu_full, wb_valid, wb_id, fence_req,
    input  issue_ready, issue_illegal, fpu_enable, fpu_instr, fpu_id, fence_done,
           inflight_cnt
  );
endinterface

// File: rtl/rvfpm_issue_ctrl.sv
// RV32F issue controller + FP-register scoreboard between core and rvfpm FPU.
// Optional stall/issue counters are enabled by defining RVFPM_ISSUE_PERF_EN.
module rvfpm_issue_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int X_ID_WIDTH   = 4,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic               ck,
  input  logic               rst,
  rvfpm_issue_ctrl_if.slave  io
`ifdef RVFPM_ISSUE_PERF_EN
  ,
  output logic [31:0]        stall_hazard_cnt,
  output logic [31:0]        stall_full_cnt,
  output logic [31:0]        issued_cnt
`endif
);

  localparam int CNT_W   = $clog2(MAX_INFLIGHT + 1);
  localparam int NUM_IDS = 2 ** X_ID_WIDTH;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  typedef enum logic {ST_RUN, ST_DRAIN} state_e;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       wr;
  } id_entry_t;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] funct5, rd, rs1, rs2, rs3;
  assign opcode = io.issue_instr[6:0];
  assign rd     = io.issue_instr[11:7];
  assign rs1    = io.issue_instr[19:15];
  assign rs2    = io.issue_instr[24:20];
  assign rs3    = io.issue_instr[31:27];
  assign funct5 = io.issue_instr[31:27];

  logic is_legal, writes_fp, use_rs1, use_rs2, use_rs3;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the case statement can leave it unassigned (no latch).
  always_comb begin
    is_legal  = 1'b0;
    writes_fp = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rs3   = 1'b0;
    case (opcode)
      OPC_LOAD_FP: begin
        is_legal  = 1'b1;
        writes_fp = 1'b1;
      end
      OPC_STORE_FP: begin
        is_legal = 1'b1;
        use_rs2  = 1'b1;
      end
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD: begin
        is_legal  = 1'b1;
        writes_fp = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        use_rs3   = 1'b1;
      end
      OPC_OP_FP: begin
        is_legal  = 1'b1;
        // Compares, FCVT.W and FMV.X/FCLASS write the integer file instead.
        writes_fp = !(funct5 inside {5'b10100, 5'b11000, 5'b11100});
        use_rs1   = !(funct5 inside {5'b11010, 5'b11110});
        use_rs2   = !(funct5 inside {5'b01011, 5'b11000, 5'b11010, 5'b11100, 5'b11110});
      end
      default: ;
    endcase
  end

  // Registered state
  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   pending_q, pending_d;
  id_entry_t             id_tab_q [NUM_IDS];
  id_entry_t             id_tab_d [NUM_IDS];
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fpu_enable_q, fpu_enable_d;
  logic [31:0]           fpu_instr_q, fpu_instr_d;
  logic [X_ID_WIDTH-1:0] fpu_id_q, fpu_id_d;
  logic                  fence_done_q, fence_done_d;

  logic run, hazard, id_busy, cnt_room, accept, illegal, wb_hit;

  assign run      = (state_q == ST_RUN) && !rst;
  assign hazard   = (use_rs1 && pending_q[rs1]) || (use_rs2 && pending_q[rs2]) ||
                    (use_rs3 && pending_q[rs3]) || (writes_fp && pending_q[rd]);
  assign id_busy  = id_tab_q[io.issue_id].valid;
  assign cnt_room = cnt_q < MAX_CNT;
  assign accept   = run && io.issue_valid && is_legal && !io.fpu_full &&
                    cnt_room && !id_busy && !hazard;
  assign illegal  = run && io.issue_valid && !is_legal;
  assign wb_hit   = io.wb_valid && id_tab_q[io.wb_id].valid;

  always_comb begin
    pending_d    = pending_q;
    id_tab_d     = id_tab_q;
    cnt_d        = cnt_q;
    fpu_enable_d = accept;
    fpu_instr_d  = fpu_instr_q;
    fpu_id_d     = fpu_id_q;
    state_d      = state_q;
    fence_done_d = 1'b0;

    // Retire first so that a same-cycle issue to the same rd leaves it pending.
    if (wb_hit) begin
      id_tab_d[io.wb_id] = '0;
      if (id_tab_q[io.wb_id].wr) pending_d[id_tab_q[io.wb_id].rd] = 1'b0;
    end
    if (accept) begin
      id_tab_d[io.issue_id] = '{valid: 1'b1, rd: rd, wr: writes_fp};
      if (writes_fp) pending_d[rd] = 1'b1;
      fpu_instr_d = io.issue_instr;
      fpu_id_d    = io.issue_id;
    end

    if (accept && !wb_hit && cnt_q != MAX_CNT)  cnt_d = cnt_q + CNT_ONE;
    else if (!accept && wb_hit && cnt_q != '0) cnt_d = cnt_q - CNT_ONE;

    case (state_q)
      ST_RUN:   if (io.fence_req && !(accept || illegal)) state_d = ST_DRAIN;
      ST_DRAIN: if (cnt_d == '0) begin
        state_d      = ST_RUN;
        fence_done_d = 1'b1;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q      <= ST_RUN;
      pending_q    <= '0;
      cnt_q        <= '0;
      fpu_enable_q <= 1'b0;
      fpu_instr_q  <= '0;
      fpu_id_q     <= '0;
      fence_done_q <= 1'b0;
      // NOTE: the id table is a small flop array, not RAM; it must be cleared
      // on reset because its valid bits gate acceptance and writeback.
      for (int i = 0; i < NUM_IDS; i++) id_tab_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      fpu_enable_q <= fpu_enable_d;
      fpu_instr_q  <= fpu_instr_d;
      fpu_id_q     <= fpu_id_d;
      fence_done_q <= fence_done_d;
      for (int i = 0; i < NUM_IDS; i++) id_tab_q[i] <= id_tab_d[i];
    end
  end

  assign io.issue_ready   = accept || illegal;
  assign io.issue_illegal = illegal;
  assign io.fpu_enable    = fpu_enable_q;
  assign io.fpu_instr     = fpu_instr_q;
  assign io.fpu_id        = fpu_id_q;
  assign io.fence_done    = fence_done_q;
  assign io.inflight_cnt  = cnt_q;

`ifdef RVFPM_ISSUE_PERF_EN
  logic [31:0] stall_hazard_q, stall_hazard_d;
  logic [31:0] stall_full_q, stall_full_d;
  logic [31:0] issued_q, issued_d;
  logic        blocked_sb, blocked_full;

  // Scoreboard blocking takes priority over resource blocking.
  assign blocked_sb   = run && io.issue_valid && is_legal && (hazard || id_busy);
  assign blocked_full = run && io.issue_valid && is_legal && !(hazard || id_busy) &&
                        (io.fpu_full || !cnt_room);

  always_comb begin
    stall_hazard_d = stall_hazard_q + {31'd0, blocked_sb};
    stall_full_d   = stall_full_q + {31'd0, blocked_full};
    issued_d       = issued_q + {31'd0, accept};
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      stall_hazard_q <= '0;
      stall_full_q   <= '0;
      issued_q       <= '0;
    end else begin
      stall_hazard_q <= stall_hazard_d;
      stall_full_q   <= stall_full_d;
      issued_q       <= issued_d;
    end
  end

  assign stall_hazard_cnt = stall_hazard_q;
  assign stall_full_cnt   = stall_full_q;
  assign issued_cnt       = issued_q;
`endif

endmodule

// File: tb/tb_rvfpm_issue_ctrl.sv
// Self-checking bench for rvfpm_issue_ctrl: directed scenarios plus randomized
// traffic compared against a queue-based in-flight model.
module tb_rvfpm_issue_ctrl;
  localparam int XW   = 4;
  localparam int MAXF = 4;
  localparam int CW   = $clog2(MAXF + 1);

  logic ck  = 1'b0;
  logic rst = 1'b1;
  always #5 ck = ~ck;

  rvfpm_issue_ctrl_if #(.X_ID_WIDTH(XW), .MAX_INFLIGHT(MAXF)) io ();

`ifdef RVFPM_ISSUE_PERF_EN
  logic [31:0] perf_hazard, perf_full, perf_issued;
`endif

  rvfpm_issue_ctrl #(.NUM_REGS(32), .X_ID_WIDTH(XW), .MAX_INFLIGHT(MAXF)) dut (
    .ck  (ck),
    .rst (rst),
    .io  (io)
`ifdef RVFPM_ISSUE_PERF_EN
    ,
    .stall_hazard_cnt (perf_hazard),
    .stall_full_cnt   (perf_full),
    .issued_cnt       (perf_issued)
`endif
  );

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FADD_3_1_2 = 32'h002081D3;
  localparam logic [31:0] FMUL_4_3_1 = 32'h10118253;

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input int id,
                       input bit full = 1'b0, input bit wbv = 1'b0,
                       input int wbid = 0, input bit fence = 1'b0);
    io.issue_valid = v;
    io.issue_instr = ins;
    io.issue_id    = XW'(id);
    io.fpu_full    = full;
    io.wb_valid    = wbv;
    io.wb_id       = XW'(wbid);
    io.fence_req   = fence;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] fadd(input int rdn, input int r1, input int r2);
    logic [4:0] a, b, c;
    a = 5'(rdn);
    b = 5'(r1);
    c = 5'(r2);
    return {7'b0000000, c, b, 3'b000, a, 7'b1010011};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int id;
    int rd;
    bit wr;
  } flight_t;

  flight_t fl[$];

  function automatic bit m_legal(input logic [31:0] ins);
    return ins[6:0] inside {7'h07, 7'h27, 7'h43, 7'h47, 7'h4B, 7'h4F, 7'h53};
  endfunction

  function automatic bit m_is_fma(input logic [31:0] ins);
    return ins[6:0] inside {7'h43, 7'h47, 7'h4B, 7'h4F};
  endfunction

  function automatic bit m_writes(input logic [31:0] ins);
    if (ins[6:0] == 7'h07 || m_is_fma(ins)) return 1'b1;
    if (ins[6:0] == 7'h53) return !(ins[31:27] inside {5'b10100, 5'b11000, 5'b11100});
    return 1'b0;
  endfunction

  function automatic bit m_pending(input int r);
    foreach (fl[i]) if (fl[i].wr && fl[i].rd == r) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_busy(input int id);
    foreach (fl[i]) if (fl[i].id == id) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_reg_blocked(input logic [31:0] ins);
    int srcs[$];
    logic [4:0] f5;
    f5 = ins[31:27];
    if (m_is_fma(ins)) begin
      srcs.push_back(int'(ins[19:15]));
      srcs.push_back(int'(ins[24:20]));
      srcs.push_back(int'(ins[31:27]));
    end else if (ins[6:0] == 7'h27) begin
      srcs.push_back(int'(ins[24:20]));
    end else if (ins[6:0] == 7'h53) begin
      if (!(f5 inside {5'b11010, 5'b11110})) srcs.push_back(int'(ins[19:15]));
      if (!(f5 inside {5'b01011, 5'b11000, 5'b11010, 5'b11100, 5'b11110}))
        srcs.push_back(int'(ins[24:20]));
    end
    foreach (srcs[i]) if (m_pending(srcs[i])) return 1'b1;
    return m_writes(ins) && m_pending(int'(ins[11:7]));
  endfunction

  // ---------------- directed scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, FADD_3_1_2, 1);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%0b exp=0", io.issue_ready); end
    tick();
    tick();
    checks++; if (io.fpu_enable !== 1'b0) begin errors++; $display("FAIL reset_fpu_enable got=%0b exp=0", io.fpu_enable); end
    checks++; if (io.inflight_cnt !== CW'(0)) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", io.inflight_cnt); end
    checks++; if (io.fence_done !== 1'b0) begin errors++; $display("FAIL reset_fence_done got=%0b exp=0", io.fence_done); end
    checks++; if (io.fpu_instr !== 32'h0) begin errors++; $display("FAIL reset_fpu_instr got=%0h exp=0", io.fpu_instr); end
    checks++; if (io.issue_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%0b exp=0", io.issue_illegal); end
    rst = 1'b0;
    drive(1'b0, 32'h0, 0);
  endtask

  task automatic test_basic_issue();
    do_reset();
    drive(1'b1, FADD_3_1_2, 1);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL basic_ready got=%0b exp=1", io.issue_ready); end
    checks++; if (io.issue_illegal !== 1'b0) begin errors++; $display("FAIL basic_illegal got=%0b exp=0", io.issue_illegal); end
    tick();
    drive(1'b0, 32'h0, 0);
    checks++; if (io.fpu_enable !== 1'b1) begin errors++; $display("FAIL basic_enable got=%0b exp=1", io.fpu_enable); end
    checks++; if (io.fpu_instr !== FADD_3_1_2) begin errors++; $display("FAIL basic_instr got=%0h exp=%0h", io.fpu_instr, FADD_3_1_2); end
    checks++; if (io.fpu_id !== XW'(1)) begin errors++; $display("FAIL basic_id got=%0d exp=1", io.fpu_id); end
    checks++; if (io.inflight_cnt !== CW'(1)) begin errors++; $display("FAIL basic_cnt got=%0d exp=1", io.inflight_cnt); end
    tick();
    checks++; if (io.fpu_enable !== 1'b0) begin errors++; $display("FAIL basic_enable_pulse got=%0b exp=0", io.fpu_enable); end
  endtask

  task automatic test_raw_hazard();
    do_reset();
    drive(1'b1, FADD_3_1_2, 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, FMUL_4_3_1, 2);
      checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL raw_blocked c=%0d got=%0b exp=0", c, io.issue_ready); end
      tick();
    end
    drive(1'b1, FMUL_4_3_1, 2, 1'b0, 1'b1, 1);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL raw_wb_same_cycle got=%0b exp=0", io.issue_ready); end
    tick();
    drive(1'b1, FMUL_4_3_1, 2);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL raw_after_wb got=%0b exp=1", io.issue_ready); end
    tick();
    drive(1'b0, 32'h0, 0);
    checks++; if (io.fpu_id !== XW'(2)) begin errors++; $display("FAIL raw_fpu_id got=%0d exp=2", io.fpu_id); end
    checks++; if (io.fpu_instr !== FMUL_4_3_1) begin errors++; $display("FAIL raw_fpu_instr got=%0h exp=%0h", io.fpu_instr, FMUL_4_3_1); end
    checks++; if (io.inflight_cnt !== CW'(1)) begin errors++; $display("FAIL raw_cnt got=%0d exp=1", io.inflight_cnt); end
  endtask

  task automatic test_limits();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, fadd(10 + i, 1, 2), i);
      checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL limit_fill i=%0d got=%0b exp=1", i, io.issue_ready); end
      tick();
    end
    drive(1'b1, fadd(20, 1, 2), 4);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL limit_fifth got=%0b exp=0", io.issue_ready); end
    checks++; if (io.inflight_cnt !== CW'(4)) begin errors++; $display("FAIL limit_cnt got=%0d exp=4", io.inflight_cnt); end
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 1'b1, 9);
    tick();
    checks++; if (io.inflight_cnt !== CW'(4)) begin errors++; $display("FAIL limit_unknown_wb got=%0d exp=4", io.inflight_cnt); end
    drive(1'b0, 32'h0, 0, 1'b0, 1'b1, 0);
    tick();
    checks++; if (io.inflight_cnt !== CW'(3)) begin errors++; $display("FAIL limit_wb_cnt got=%0d exp=3", io.inflight_cnt); end
    drive(1'b1, fadd(21, 1, 2), 2);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL limit_dup_id got=%0b exp=0", io.issue_ready); end
    drive(1'b1, fadd(21, 1, 2), 0);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL limit_freed_id got=%0b exp=1", io.issue_ready); end
    tick();
    do_reset();
    drive(1'b1, FADD_3_1_2, 1, 1'b1);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL limit_fpu_full got=%0b exp=0", io.issue_ready); end
    tick();
    checks++; if (io.inflight_cnt !== CW'(0)) begin errors++; $display("FAIL limit_full_cnt got=%0d exp=0", io.inflight_cnt); end
    drive(1'b1, FADD_3_1_2, 1, 1'b0);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL limit_full_released got=%0b exp=1", io.issue_ready); end
    tick();
    drive(1'b0, 32'h0, 0);
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 32'h00000033, 3);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got=%0b exp=1", io.issue_ready); end
    checks++; if (io.issue_illegal !== 1'b1) begin errors++; $display("FAIL illegal_flag got=%0b exp=1", io.issue_illegal); end
    tick();
    drive(1'b0, 32'h0, 0);
    checks++; if (io.fpu_enable !== 1'b0) begin errors++; $display("FAIL illegal_enable got=%0b exp=0", io.fpu_enable); end
    checks++; if (io.inflight_cnt !== CW'(0)) begin errors++; $display("FAIL illegal_cnt got=%0d exp=0", io.inflight_cnt); end
    checks++; if (io.issue_illegal !== 1'b0) begin errors++; $display("FAIL illegal_pulse got=%0b exp=0", io.issue_illegal); end
    drive(1'b1, FADD_3_1_2, 3);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL illegal_untracked got=%0b exp=1", io.issue_ready); end
    tick();
    drive(1'b0, 32'h0, 0);
  endtask

  task automatic test_fence();
    do_reset();
    drive(1'b1, fadd(10, 1, 2), 0);
    tick();
    drive(1'b1, fadd(11, 1, 2), 1);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    drive(1'b1, fadd(12, 1, 2), 5);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL fence_drain_ready got=%0b exp=0", io.issue_ready); end
    checks++; if (io.inflight_cnt !== CW'(2)) begin errors++; $display("FAIL fence_cnt2 got=%0d exp=2", io.inflight_cnt); end
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 1'b1, 0);
    tick();
    checks++; if (io.fence_done !== 1'b0) begin errors++; $display("FAIL fence_early_done got=%0b exp=0", io.fence_done); end
    drive(1'b0, 32'h0, 0, 1'b0, 1'b1, 1);
    tick();
    checks++; if (io.inflight_cnt !== CW'(0)) begin errors++; $display("FAIL fence_cnt0 got=%0d exp=0", io.inflight_cnt); end
    checks++; if (io.fence_done !== 1'b1) begin errors++; $display("FAIL fence_done got=%0b exp=1", io.fence_done); end
    drive(1'b1, fadd(12, 1, 2), 5);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL fence_back_to_run got=%0b exp=1", io.issue_ready); end
    tick();
    checks++; if (io.fence_done !== 1'b0) begin errors++; $display("FAIL fence_done_once got=%0b exp=0", io.fence_done); end
    // Empty drain, then fence held high re-enters DRAIN.
    do_reset();
    drive(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    drive(1'b1, FADD_3_1_2, 1);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL fence_empty_drain got=%0b exp=0", io.issue_ready); end
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b1);
    checks++; if (io.fence_done !== 1'b1) begin errors++; $display("FAIL fence_empty_done got=%0b exp=1", io.fence_done); end
    tick();
    drive(1'b1, FADD_3_1_2, 1);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL fence_reenter got=%0b exp=0", io.issue_ready); end
    checks++; if (io.fence_done !== 1'b0) begin errors++; $display("FAIL fence_reenter_done got=%0b exp=0", io.fence_done); end
    tick();
    drive(1'b0, 32'h0, 0);
    checks++; if (io.fence_done !== 1'b1) begin errors++; $display("FAIL fence_second_done got=%0b exp=1", io.fence_done); end
    tick();
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(1'b1, fadd(10, 1, 2), 0);
    tick();
    drive(1'b1, fadd(11, 1, 2), 5, 1'b0, 1'b1, 0);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL same_ready got=%0b exp=1", io.issue_ready); end
    tick();
    drive(1'b0, 32'h0, 0);
    checks++; if (io.inflight_cnt !== CW'(1)) begin errors++; $display("FAIL same_cnt got=%0d exp=1", io.inflight_cnt); end
    checks++; if (io.fpu_id !== XW'(5)) begin errors++; $display("FAIL same_fpu_id got=%0d exp=5", io.fpu_id); end
  endtask

  task automatic test_reset_mid_drain();
    do_reset();
    drive(1'b1, fadd(10, 1, 2), 0);
    tick();
    drive(1'b0, 32'h0, 0, 1'b0, 1'b0, 0, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b1, fadd(11, 1, 2), 1);
    checks++; if (io.issue_ready !== 1'b0) begin errors++; $display("FAIL rstdrain_ready got=%0b exp=0", io.issue_ready); end
    tick();
    checks++; if (io.inflight_cnt !== CW'(0)) begin errors++; $display("FAIL rstdrain_cnt got=%0d exp=0", io.inflight_cnt); end
    checks++; if (io.fpu_id !== XW'(0)) begin errors++; $display("FAIL rstdrain_fpu_id got=%0d exp=0", io.fpu_id); end
    rst = 1'b0;
    drive(1'b1, fadd(10, 1, 2), 0);
    checks++; if (io.issue_ready !== 1'b1) begin errors++; $display("FAIL rstdrain_run got=%0b exp=1", io.issue_ready); end
    tick();
    drive(1'b0, 32'h0, 0);
  endtask

  // ---------------- randomized traffic vs model ----------------
  task automatic test_random();
    logic [31:0] ins;
    bit v, full, wbv, fence, drain, e_ill, e_acc, e_done;
    int id, wbid;
    flight_t f;
    drain = 1'b0;
    fl.delete();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      ins = $urandom();
      ins[11:7]  = 5'($urandom_range(0, 5));
      ins[19:15] = 5'($urandom_range(0, 5));
      ins[24:20] = 5'($urandom_range(0, 5));
      case ($urandom_range(0, 8))
        0: ins[6:0] = 7'h07;
        1: ins[6:0] = 7'h27;
        2: ins[6:0] = 7'h43;
        3: ins[6:0] = 7'h4F;
        4: ins[6:0] = 7'h33;
        default: ins[6:0] = 7'h53;
      endcase
      if (m_is_fma(ins)) ins[31:27] = 5'($urandom_range(0, 5));
      else if (ins[6:0] == 7'h53)
        case ($urandom_range(0, 8))
          0: ins[31:27] = 5'b00000;
          1: ins[31:27] = 5'b00010;
          2: ins[31:27] = 5'b01011;
          3: ins[31:27] = 5'b10100;
          4: ins[31:27] = 5'b11000;
          5: ins[31:27] = 5'b11010;
          6: ins[31:27] = 5'b11100;
          7: ins[31:27] = 5'b11110;
          default: ins[31:27] = 5'b00100;
        endcase
      v     = $urandom_range(0, 3) != 0;
      id    = $urandom_range(0, 7);
      full  = $urandom_range(0, 4) == 0;
      wbv   = $urandom_range(0, 2) == 0;
      fence = $urandom_range(0, 24) == 0;
      if (fl.size() > 0 && $urandom_range(0, 3) != 0) wbid = fl[$urandom_range(0, fl.size() - 1)].id;
      else wbid = $urandom_range(0, 15);

      e_ill = !drain && v && !m_legal(ins);
      e_acc = !drain && v && m_legal(ins) && !full && fl.size() < MAXF &&
              !m_busy(id) && !m_reg_blocked(ins);

      drive(v, ins, id, full, wbv, wbid, fence);
      checks++; if (io.issue_ready !== (e_ill || e_acc)) begin errors++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, io.issue_ready, e_ill || e_acc); end
      checks++; if (io.issue_illegal !== e_ill) begin errors++; $display("FAIL rnd_illegal n=%0d got=%0b exp=%0b", n, io.issue_illegal, e_ill); end
      tick();

      if (wbv)
        for (int i = 0; i < fl.size(); i++)
          if (fl[i].id == wbid) begin
            fl.delete(i);
            break;
          end
      if (e_acc) begin
        f.id = id;
        f.rd = int'(ins[11:7]);
        f.wr = m_writes(ins);
        fl.push_back(f);
      end
      e_done = 1'b0;
      if (drain) begin
        if (fl.size() == 0) begin
          drain  = 1'b0;
          e_done = 1'b1;
        end
      end else if (fence && !(e_ill || e_acc)) begin
        drain = 1'b1;
      end

      checks++; if (io.fpu_enable !== e_acc) begin errors++; $display("FAIL rnd_enable n=%0d got=%0b exp=%0b", n, io.fpu_enable, e_acc); end
      if (e_acc) begin
        checks++; if (io.fpu_instr !== ins || io.fpu_id !== XW'(id)) begin errors++; $display("FAIL rnd_fwd n=%0d got=%0h/%0d exp=%0h/%0d", n, io.fpu_instr, io.fpu_id, ins, id); end
      end
      checks++; if (io.inflight_cnt !== CW'(fl.size())) begin errors++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, io.inflight_cnt, fl.size()); end
      checks++; if (io.fence_done !== e_done) begin errors++; $display("FAIL rnd_fence_done n=%0d got=%0b exp=%0b", n, io.fence_done, e_done); end
    end
    drive(1'b0, 32'h0, 0);
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_raw_hazard();
    test_limits();
    test_illegal();
    test_fence();
    test_same_cycle();
    test_reset_mid_drain();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvfpm_issue_ctrl.md
Name: rvfpm_issue_ctrl

Overview:
Issue controller and scoreboard between the integer core's coprocessor issue interface and the rvfpm FPU model.
- Decodes each offered RV32F instruction and blocks it on FP-register RAW/WAW hazards, FPU back-pressure, in-flight limit or duplicate id.
- Forwards accepted instructions as single-cycle enable pulses to the FPU.
- Tracks in-flight ids until writeback, and provides a drain (fence) sequence.

Parameters:
- NUM_REGS, 32, FP register count; scoreboard width.
- X_ID_WIDTH, 4, instruction id width.
- MAX_INFLIGHT, 4, max issued-but-not-retired instructions; matches FPU PIPELINE_STAGES; 1..2**X_ID_WIDTH.

Ports:
- ck  in  1  clock.
- rst  in  1  synchronous active-high reset.
- issue_valid  in  1  core offers an instruction.
- issue_instr  in  32  instruction word.
- issue_id  in  X_ID_WIDTH  instruction id.
- issue_ready  out  1  instruction accepted this cycle (handshake = valid & ready).
- issue_illegal  out  1  one-cycle pulse: offered opcode is not an F opcode; consumed, not forwarded.
- fpu_enable  out  1  one-cycle issue strobe to the FPU.
- fpu_instr  out  32  registered instruction to the FPU.
- fpu_id  out  X_ID_WIDTH  registered id to the FPU.
- fpu_full  in  1  FPU pipeline full (stall).
- wb_valid  in  1  FPU retires an instruction.
- wb_id  in  X_ID_WIDTH  id of the retiring instruction.
- fence_req  in  1  request a drain of all in-flight work.
- fence_done  out  1  one-cycle pulse when the drain completes.
- inflight_cnt  out  clog2(MAX_INFLIGHT+1)  current in-flight count.

Behaviour:
- Reset:
  - All outputs 0; scoreboard cleared; id table cleared; state RUN.
  - Reset asserted mid-operation discards all in-flight tracking in the same cycle.
- Decode (combinational, on issue_instr):
  - Valid F opcodes: LOAD-FP 0000111, STORE-FP 0100111, FMADD/FMSUB/FNMSUB/FNMADD 1000011/1000111/1001011/1001111, OP-FP 1010011.
  - Writes FP rd: LOAD-FP, all FMA opcodes, OP-FP except funct5 10100 (compare), 11000 (FCVT.W), 11100 (FMV.X/FCLASS).
  - FP sources:
    - FMA: rs1, rs2, rs3.
    - STORE-FP: rs2.
    - OP-FP: rs1, plus rs2 unless funct5 is 01011, 11000, 11010, 11100, 11110; funct5 11010 and 11110 read no FP source.
- Accept condition (issue_ready=1) requires all of:
  - state RUN;
  - issue_valid;
  - opcode legal;
  - !fpu_full;
  - inflight_cnt < MAX_INFLIGHT;
  - issue_id not in the id table;
  - no pending bit set on any FP source or FP rd.
- Illegal opcode while in RUN: issue_ready=1 and issue_illegal=1 the same cycle; no FPU strobe; no tracking update.
- Latency: accept in cycle N → fpu_enable=1 with fpu_instr/fpu_id in cycle N+1. fpu_enable is never high in two consecutive cycles for the same id.
- On accept:
  - Set the id table entry [issue_id] = {valid, rd, writes_fp}.
  - Set pending[rd] if writes_fp.
  - inflight_cnt increments.
- On wb_valid:
  - Clear the id table entry [wb_id] and its pending rd bit.
  - inflight_cnt decrements.
  - wb_valid for an id not in the table is ignored; the count is unchanged.
- Same-cycle accept and writeback:
  - Count is unchanged (+1 −1).
  - If the retiring rd equals the issuing rd, pending stays set (set wins).
  - A writeback clearing a hazard is not visible to acceptance until the next cycle (registered scoreboard).
- FSM:
  - RUN → DRAIN on fence_req, in any cycle with no accept; issue_ready is forced 0 in DRAIN.
  - DRAIN → RUN when inflight_cnt==0; fence_done pulses 1 on that transition.
  - fence_req with inflight_cnt==0 already: enter DRAIN for one cycle, then fence_done.
  - fence_req held high after done: re-enters DRAIN.
- Arithmetic: inflight_cnt saturates at 0 and MAX_INFLIGHT; no wrap-around.

Optional Feature:
RVFPM_ISSUE_PERF_EN
- Defined: adds outputs stall_hazard_cnt (32), stall_full_cnt (32) and issued_cnt (32).
  - Counters are wrapping, reset to 0, and increment per cycle of: valid-but-blocked-by-scoreboard, valid-but-blocked-by-fpu_full/inflight limit, and accepted-legal, respectively.
  - Hazard has priority when both stall causes are present.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then issue FADD.S f3,f1,f2 (0x002081D3) id 1 → issue_ready=1 that cycle; next cycle fpu_enable=1, fpu_instr=0x002081D3, fpu_id=1; inflight_cnt=1.
- RAW hazard:
  - Issue FADD.S writing f3 (id 1), then FMUL.S f4,f3,f1 (id 2) → id 2 ready=0 until wb_valid id 1.
  - id 2 is accepted the cycle after the writeback.
- Limits:
  - Issue 4 independent ops with ids 0–3 and no writeback → 5th is blocked (inflight_cnt=4).
  - Hold fpu_full=1 → ready=0 even with inflight_cnt=0.
  - Reuse of id 2 while it is in flight → blocked.
- Illegal opcode:
  - Offer 0x00000033 (ADD) → issue_ready=1, issue_illegal=1.
  - fpu_enable stays 0; count unchanged.
- Fence:
  - Two in flight, assert fence_req → ready=0.
  - Retire both → fence_done pulses exactly once in the cycle inflight_cnt reaches 0, then RUN.
- Same-cycle events:
  - wb_valid id 0 together with accept of id 5 → inflight_cnt unchanged.
  - Assert rst mid-drain → all outputs 0, state RUN next cycle.
